spi_slave: RTL and testbench

//  SPI target (slave) for the peer side of our SPI master link. All SPI pins are

---
 rtl/spi_slave.sv | 154 +++++++++++++++
 tb/tb_spi_slave.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI target with all SPI pins synchronized into clk, CPOL/CPHA modes and a one-entry TX buffer.
// Optional sticky status register enabled by defining SPI_SLAVE_STATUS_EN.
module spi_slave #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD   = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe
`ifdef SPI_SLAVE_STATUS_EN
  ,
  input  logic                  status_clr,
  output logic [1:0]            status
`endif
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_d, cs_d;
  logic                    sclk_s, cs_s, mosi_s;
  logic                    sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                    sample_edge, change_edge;
  logic [CW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   tx_shift, rx_shift, buf_data, load_word;
  logic                    buf_full, accept, load, frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // Modes 0 and 3 (cpol == cpha) sample on the rising edge.
  assign sample_edge = (cpol == cpha) ? sclk_rise : sclk_fall;
  assign change_edge = (cpol == cpha) ? sclk_fall : sclk_rise;

  // Handshake: a word transfers on any clk where tx_valid && tx_ready; tx_valid
  // may not be withdrawn by the producer's expectations, tx_ready means buffer empty.
  assign tx_ready   = ~buf_full;
  assign accept     = tx_valid & tx_ready;
  assign frame_done = (state == ACTIVE) & ~cs_rise & sample_edge & (bit_cnt == LAST);
  assign load       = ((state == IDLE) & cs_fall) | frame_done;
  assign load_word  = buf_full ? buf_data : FILL_WORD;
  assign miso       = busy & tx_shift[DATA_WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      miso_oe  <= 1'b0;
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      rx_valid <= 1'b0;
      // A load in the same cycle as an accept takes the old content; the new word stays.
      if (accept) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= ACTIVE;
            tx_shift <= load_word;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            miso_oe  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
          end else if (sample_edge) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt == LAST) begin
              rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              tx_shift <= load_word;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (change_edge && bit_cnt != '0) begin
            // bit_cnt==0 keeps the MSB on a CPHA=1 leading edge and the reloaded word intact.
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  logic underrun_set, abort_set;
  assign underrun_set = load & ~buf_full;
  assign abort_set    = (state == ACTIVE) & cs_rise & (bit_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= 2'b00;
    end else begin
      status[1] <= underrun_set ? 1'b1 : (status_clr ? 1'b0 : status[1]);
      status[0] <= abort_set    ? 1'b1 : (status_clr ? 1'b0 : status[0]);
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bench-side SPI master in all four modes and a word-level model.
module tb_spi_slave;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, miso, miso_oe;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
  logic       status_clr = 1'b0;
  logic [1:0] status;
`endif

  spi_slave dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
`ifdef SPI_SLAVE_STATUS_EN
    , .status_clr(status_clr), .status(status)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int long_pulse = 0;
  logic rx_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] buf_q[$];

  always @(negedge clk) begin
    if (rx_valid && !rx_prev) got_q.push_back(rx_data);
    if (rx_valid && rx_prev) long_pulse <= long_pulse + 1;
    rx_prev <= rx_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p; cpha = h; sclk = p;
    tick(8);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    tick(6);
  endtask

  // Model: the word a frame shifts out is the buffered word, or 0xFF when empty.
  function automatic logic [7:0] model_load();
    if (buf_q.size() != 0) return buf_q.pop_front();
    return 8'hFF;
  endfunction

  task automatic write_tx(input logic [7:0] d);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin tick(1); n++; end
    if (tx_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL tx_ready_wait got=%b exp=1", tx_ready);
    end
    tx_data = d; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    buf_q.push_back(d);
    total++;
    if (tx_ready !== 1'b0) begin
      bad++; $display("FAIL tx_ready_after_accept got=%b exp=0", tx_ready);
    end
  endtask

  task automatic xfer(input logic [7:0] w, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = w[7-i]; tick(HALF);
        sclk = ~cpol; got = {got[6:0], miso}; tick(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol; mosi = w[7-i]; tick(HALF);
        sclk = cpol; got = {got[6:0], miso}; tick(HALF);
      end
    end
  endtask

  task automatic test_reset();
    tick(3);
    total++;
    if ({tx_ready, rx_data, rx_valid, busy, miso, miso_oe} !== {1'b1, 8'h00, 4'b0000}) begin
      bad++; $display("FAIL reset_values got=%b exp=%b",
        {tx_ready, rx_data, rx_valid, busy, miso, miso_oe}, {1'b1, 8'h00, 4'b0000});
    end
    rst = 1'b0;
    tick(4);
    total++;
    if ({tx_ready, busy, miso_oe, miso} !== 4'b1000) begin
      bad++; $display("FAIL after_reset got=%b exp=1000", {tx_ready, busy, miso_oe, miso});
    end
  endtask

  task automatic test_modes();
    logic [7:0] g, e, m, tw;
    for (int mode = 0; mode < 4; mode++) begin
      set_mode(mode[1], mode[0]);
      tw = (mode == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      m  = (mode == 0) ? 8'h3C : 8'($urandom_range(0, 255));
      write_tx(tw);
      cs_low();
      e = model_load();
      total++;
      if ({busy, miso_oe, tx_ready} !== 3'b111) begin
        bad++; $display("FAIL mode%0d_start got=%b exp=111", mode, {busy, miso_oe, tx_ready});
      end
      xfer(m, 8, g);
      exp_q.push_back(m);
      void'(model_load());
      cs_high();
      total++;
      if (g !== e) begin bad++; $display("FAIL mode%0d_miso got=%h exp=%h", mode, g, e); end
      total++;
      if ({busy, miso_oe, miso} !== 3'b000) begin
        bad++; $display("FAIL mode%0d_end got=%b exp=000", mode, {busy, miso_oe, miso});
      end
      total++;
      if (got_q.size() != exp_q.size()) begin
        bad++; $display("FAIL mode%0d_rx_count got=%0d exp=%0d", mode, got_q.size(), exp_q.size());
      end
      while (exp_q.size() != 0 && got_q.size() != 0) begin
        total++;
        e = exp_q.pop_front(); g = got_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL mode%0d_rx got=%h exp=%h", mode, g, e); end
      end
      exp_q.delete(); got_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g1, g2, e1, e2, e, g;
    set_mode(1'b0, 1'b0);
    write_tx(8'h11);
    cs_low();
    e1 = model_load();
    fork
      xfer(8'hC3, 8, g1);
      begin tick(20); write_tx(8'h22); end
    join
    exp_q.push_back(8'hC3);
    e2 = model_load();
    xfer(8'h5E, 8, g2);
    exp_q.push_back(8'h5E);
    void'(model_load());
    cs_high();
    total++;
    if (g1 !== e1) begin bad++; $display("FAIL b2b_miso1 got=%h exp=%h", g1, e1); end
    total++;
    if (g2 !== e2) begin bad++; $display("FAIL b2b_miso2 got=%h exp=%h", g2, e2); end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b_rx_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      total++;
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin bad++; $display("FAIL b2b_rx got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_underrun();
    logic [7:0] g, e;
    set_mode(1'b1, 1'b1);
`ifdef SPI_SLAVE_STATUS_EN
    status_clr = 1'b1; tick(1); status_clr = 1'b0; tick(1);
    total++;
    if (status !== 2'b00) begin bad++; $display("FAIL status_clear got=%b exp=00", status); end
`endif
    cs_low();
    e = model_load();
    xfer(8'h96, 8, g);
    exp_q.push_back(8'h96);
    void'(model_load());
    cs_high();
    total++;
    if (g !== e) begin bad++; $display("FAIL underrun_miso got=%h exp=%h", g, e); end
`ifdef SPI_SLAVE_STATUS_EN
    total++;
    if (status[1] !== 1'b1) begin bad++; $display("FAIL underrun_status got=%b exp=1", status[1]); end
`endif
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h96) begin
      bad++; $display("FAIL underrun_rx got_n=%0d exp_n=1", got_q.size());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_abort();
    logic [7:0] g, e;
    set_mode(1'b0, 1'b1);
`ifdef SPI_SLAVE_STATUS_EN
    status_clr = 1'b1; tick(1); status_clr = 1'b0; tick(1);
`endif
    write_tx(8'h6B);
    cs_low();
    void'(model_load());
    xfer(8'hF0, 3, g);
    cs_high();
    total++;
    if ({busy, miso_oe, miso} !== 3'b000) begin
      bad++; $display("FAIL abort_state got=%b exp=000", {busy, miso_oe, miso});
    end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL abort_rx_count got=%0d exp=0", got_q.size()); end
`ifdef SPI_SLAVE_STATUS_EN
    total++;
    if (status[0] !== 1'b1) begin bad++; $display("FAIL abort_status got=%b exp=1", status[0]); end
`endif
    cs_low();
    e = model_load();
    xfer(8'h4D, 8, g);
    void'(model_load());
    cs_high();
    total++;
    if (g !== e) begin bad++; $display("FAIL abort_next_miso got=%h exp=%h", g, e); end
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h4D) begin
      bad++; $display("FAIL abort_next_rx got_n=%0d exp=4d", got_q.size());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] g, e;
    set_mode(1'b0, 1'b0);
    write_tx(8'h5A);
    cs_low();
    void'(model_load());
    xfer(8'hFF, 4, g);
    write_tx(8'h77);
    rst = 1'b1; cs_n = 1'b1; sclk = cpol; mosi = 1'b0;
    tick(1);
    total++;
    if ({tx_ready, rx_data, rx_valid, busy, miso, miso_oe} !== {1'b1, 8'h00, 4'b0000}) begin
      bad++; $display("FAIL reset_mid got=%b exp=%b",
        {tx_ready, rx_data, rx_valid, busy, miso, miso_oe}, {1'b1, 8'h00, 4'b0000});
    end
    buf_q.delete();
    tick(2);
    rst = 1'b0;
    tick(6);
    cs_low();
    e = model_load();
    xfer(8'h81, 8, g);
    void'(model_load());
    cs_high();
    total++;
    if (g !== e) begin bad++; $display("FAIL reset_mid_next_miso got=%h exp=%h", g, e); end
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
      bad++; $display("FAIL reset_mid_rx got_n=%0d exp=81", got_q.size());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] g, e, m, ex;
    int nfr;
    for (int k = 0; k < 10; k++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) write_tx(8'($urandom_range(0, 255)));
      nfr = $urandom_range(1, 3);
      cs_low();
      ex = model_load();
      for (int f = 0; f < nfr; f++) begin
        m = 8'($urandom_range(0, 255));
        fork
          xfer(m, 8, g);
          begin
            if ($urandom_range(0, 1) == 1) begin
              tick($urandom_range(10, 60));
              write_tx(8'($urandom_range(0, 255)));
            end
          end
        join
        exp_q.push_back(m);
        total++;
        if (g !== ex) begin bad++; $display("FAIL rand%0d_f%0d_miso got=%h exp=%h", k, f, g, ex); end
        ex = model_load();
      end
      cs_high();
      total++;
      if (got_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand%0d_rx_count got=%0d exp=%0d", k, got_q.size(), exp_q.size());
      end
      while (exp_q.size() != 0 && got_q.size() != 0) begin
        total++;
        e = exp_q.pop_front(); g = got_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL rand%0d_rx got=%h exp=%h", k, g, e); end
      end
      exp_q.delete(); got_q.delete();
    end
    total++;
    if (long_pulse != 0) begin bad++; $display("FAIL rx_valid_width got=%0d exp=0", long_pulse); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
